// File: rtl/mesh_noc_pkg.sv
// Shared constants and types for the mesh tile router.
// Flit layout: [FLIT_W-1]=head, [FLIT_W-2]=tail, the rest is payload.
package mesh_noc_pkg;

  localparam int FLIT_W   = 34;
  localparam int HEAD_BIT = FLIT_W - 1;
  localparam int TAIL_BIT = FLIT_W - 2;
  localparam int NUM_IN   = 5;
  localparam int CNT_W    = 16;

  localparam int PORT_N = 0;
  localparam int PORT_S = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mesh_rr_pick.sv
// Rotate-priority picker: first eligible index at or after ptr_i, wrapping modulo N.
module mesh_rr_pick
  import mesh_noc_pkg::*;
#(
  parameter int N  = NUM_IN,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          any_o
);

  int   idx;
  logic hit;

  // Walk the ring once from ptr_i; the first hit masks all later ones.
  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    idx   = 0;
    hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx        = (int'(ptr_i) + k) % N;
      hit        = elig_i[idx] & ~any_o;
      gnt_o[idx] = hit;
      any_o      = any_o | hit;
    end
  end

endmodule

// File: rtl/mesh_out_port_arb.sv
// Wormhole output-port arbiter: round-robin grant on head flits, held until the
// tail passes, feeding one registered valid/ready output stage.
module mesh_out_port_arb
  import mesh_noc_pkg::*;
#(
  parameter int NUM_IN = mesh_noc_pkg::NUM_IN,
  parameter int FLIT_W = mesh_noc_pkg::FLIT_W,
  parameter int CNT_W  = mesh_noc_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        req_valid,
  input  logic [NUM_IN*FLIT_W-1:0] req_flit,
  output logic [NUM_IN-1:0]        req_ready,
  output logic                     out_valid,
  output logic [FLIT_W-1:0]        out_flit,
  input  logic                     out_ready,
  output logic [NUM_IN-1:0]        grant,
  output logic                     locked,
  output logic [CNT_W-1:0]         pkt_count,
  output logic                     err
);

  localparam int PTR_W    = $clog2(NUM_IN);
  localparam int HEAD_IDX = FLIT_W - 1;
  localparam int TAIL_IDX = FLIT_W - 2;

  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_IN-1:0]   grant_q, grant_d;
  logic                first_q, first_d;
  logic                out_valid_q, out_valid_d;
  logic [FLIT_W-1:0]   out_flit_q, out_flit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [NUM_IN-1:0]   elig_s;
  logic [NUM_IN-1:0]   pick_s;
  logic                any_s;
  logic                can_load_s;
  logic                xfer_s;
  logic [FLIT_W-1:0]   sel_flit_s;
  logic [PTR_W-1:0]    owner_idx_s;

  mesh_rr_pick #(.N(NUM_IN), .PW(PTR_W)) u_pick (
    .elig_i (elig_s),
    .ptr_i  (ptr_q),
    .gnt_o  (pick_s),
    .any_o  (any_s)
  );

  // Eligibility, owner flit mux and owner index decode from the one-hot grant.
  always_comb begin
    elig_s      = '0;
    sel_flit_s  = '0;
    owner_idx_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      elig_s[i]   = req_valid[i] & req_flit[i*FLIT_W + HEAD_IDX];
      sel_flit_s  = sel_flit_s | (req_flit[i*FLIT_W +: FLIT_W] & {FLIT_W{grant_q[i]}});
      owner_idx_s = owner_idx_s | (grant_q[i] ? PTR_W'(i) : '0);
    end
  end

  // Only the owner may push, and only when the output register can take a flit.
  always_comb begin
    can_load_s = ~out_valid_q | out_ready;
    if ((state_q == ST_LOCKED) && can_load_s) begin
      req_ready = grant_q;
    end else begin
      req_ready = '0;
    end
    xfer_s = |(req_valid & req_ready);
  end

  // Arbitration FSM, output register, packet counter and sticky error.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    first_d     = first_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_flit_d  = out_flit_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          state_d = ST_LOCKED;
          grant_d = pick_s;
          first_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (xfer_s) begin
          first_d = 1'b0;
          // A head in mid-packet is flagged but still forwarded.
          err_d   = err_q | (sel_flit_s[HEAD_IDX] & ~first_q);
          if (sel_flit_s[TAIL_IDX]) begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = (owner_idx_s == PTR_W'(NUM_IN - 1)) ? '0 : owner_idx_s + PTR_W'(1);
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          end else begin
            state_d = ST_LOCKED;
          end
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_flit_d  = sel_flit_s;
    end else if (can_load_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset drops any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign grant     = grant_q;
  assign locked    = (state_q == ST_LOCKED);
  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;
  assign pkt_count = cnt_q;
  assign err       = err_q;

endmodule
